// File: rtl/wb_fb_arbiter_if.sv
// Wishbone bus bundle used for both arbiter master ports and the shared
// DDR2 frame-buffer slave port.
interface wb_fb_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   adr;
  logic [DW-1:0]   wdat;
  logic [DW/8-1:0] sel;
  logic            we;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic            cyc;
  logic            stb;
  logic            ack;
  logic            err;
  logic            rty;
  logic [DW-1:0]   rdat;

  modport master (
    output adr, wdat, sel, we, cti, bte, cyc, stb,
    input  ack, err, rty, rdat
  );

  modport slave (
    input  adr, wdat, sel, we, cti, bte, cyc, stb,
    output ack, err, rty, rdat
  );
endinterface

// File: rtl/wb_fb_arbiter.sv
// Two-master Wishbone arbiter for the frame-buffer port: display (m0) has fixed
// priority, the writer (m1) is protected by a starvation limit, and a watchdog
// turns a hung slave cycle into an error.
module wb_fb_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 64,
  parameter int TIMEOUT      = 1024
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst_n,
  wb_fb_arbiter_if.slave        m0,
  wb_fb_arbiter_if.slave        m1,
  wb_fb_arbiter_if.master       s,
  output logic [1:0]            gnt_o,
  output logic                  timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] WDOG_MAX   = TW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   starve_cnt;
  logic [TW-1:0]   wdog_cnt;
  logic            timeout_q;

  logic [AW-1:0]   x_adr;
  logic [DW-1:0]   x_wdat;
  logic [DW/8-1:0] x_sel;
  logic            x_we;
  logic [2:0]      x_cti;
  logic [1:0]      x_bte;
  logic            x_cyc;
  logic            x_stb;

  logic            granted;
  logic            x_live;
  logic            resp;
  logic            abort;
  logic            cycle_end;
  logic            release_gnt;
  logic            starve_hit;
  logic            r_ack, r_err, r_rty;

  // Request bundle of whichever master currently owns the slave; zero in IDLE.
  always_comb begin
    x_adr  = '0;
    x_wdat = '0;
    x_sel  = '0;
    x_we   = 1'b0;
    x_cti  = 3'b000;
    x_bte  = 2'b00;
    x_cyc  = 1'b0;
    x_stb  = 1'b0;
    case (state_q)
      GNT0: begin
        x_adr  = m0.adr;
        x_wdat = m0.wdat;
        x_sel  = m0.sel;
        x_we   = m0.we;
        x_cti  = m0.cti;
        x_bte  = m0.bte;
        x_cyc  = m0.cyc;
        x_stb  = m0.stb;
      end
      GNT1: begin
        x_adr  = m1.adr;
        x_wdat = m1.wdat;
        x_sel  = m1.sel;
        x_we   = m1.we;
        x_cti  = m1.cti;
        x_bte  = m1.bte;
        x_cyc  = m1.cyc;
        x_stb  = m1.stb;
      end
      default: ;
    endcase
  end

  assign granted     = (state_q != IDLE);
  assign x_live      = x_cyc & x_stb;
  assign resp        = s.ack | s.err | s.rty;
  // Abort fires on the count value alone, so a late response in that cycle is dropped.
  assign abort       = x_live & (wdog_cnt == WDOG_MAX);
  assign cycle_end   = s.err | s.rty |
                       (s.ack & ((x_cti == 3'b000) || (x_cti == 3'b111)));
  assign release_gnt = granted & (~x_cyc | abort | cycle_end);
  assign starve_hit  = (STARVE_LIMIT != 0) && (starve_cnt == STARVE_MAX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m1.cyc && starve_hit) state_d = GNT1;
        else if (m0.cyc)          state_d = GNT0;
        else if (m1.cyc)          state_d = GNT1;
      end
      GNT0, GNT1: begin
        if (release_gnt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign s.adr  = x_adr;
  assign s.wdat = x_wdat;
  assign s.sel  = x_sel;
  assign s.we   = x_we;
  assign s.cti  = x_cti;
  assign s.bte  = x_bte;
  assign s.cyc  = x_cyc & ~abort;
  assign s.stb  = x_live & ~abort;

  assign r_ack = granted & s.ack & ~abort;
  assign r_err = granted & ((s.err & ~abort) | abort);
  assign r_rty = granted & s.rty & ~abort;

  assign m0.ack  = (state_q == GNT0) & r_ack;
  assign m0.err  = (state_q == GNT0) & r_err;
  assign m0.rty  = (state_q == GNT0) & r_rty;
  assign m1.ack  = (state_q == GNT1) & r_ack;
  assign m1.err  = (state_q == GNT1) & r_err;
  assign m1.rty  = (state_q == GNT1) & r_rty;
  assign m0.rdat = s.rdat;
  assign m1.rdat = s.rdat;

  assign gnt_o     = {state_q == GNT1, state_q == GNT0};
  assign timeout_o = timeout_q;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // m1 wait time, counted outside GNT1 and reset whenever m1 stops asking.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      starve_cnt <= '0;
    end else if (!m1.cyc) begin
      starve_cnt <= '0;
    end else if (state_q != GNT1) begin
      if (state_d == GNT1)              starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wdog_cnt <= '0;
    end else if (granted && x_live && !resp && !abort) begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end else begin
      wdog_cnt <= '0;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n)  timeout_q <= 1'b0;
    else if (abort) timeout_q <= 1'b1;
  end

endmodule

// File: tb/tb_wb_fb_arbiter.sv
// Directed and randomized bench for wb_fb_arbiter, checked every cycle against
// a behavioural ownership model.
module tb_wb_fb_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int TO = 16;

  logic       wb_clk = 1'b0;
  logic       wb_rst_n;
  logic [1:0] gnt;
  logic       tflag_dut;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Model: owner 0 = nobody, 1 = m0, 2 = m1.
  int owner;
  int wait1;
  int stall;
  bit tf;

  always #5 wb_clk = ~wb_clk;

  wb_fb_arbiter_if #(.AW(AW), .DW(DW)) m0_bus ();
  wb_fb_arbiter_if #(.AW(AW), .DW(DW)) m1_bus ();
  wb_fb_arbiter_if #(.AW(AW), .DW(DW)) s_bus ();

  wb_fb_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .wb_clk    (wb_clk),
    .wb_rst_n  (wb_rst_n),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .s         (s_bus),
    .gnt_o     (gnt),
    .timeout_o (tflag_dut)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = 0;
    wait1 = 0;
    stall = 0;
    tf    = 1'b0;
  endtask

  task automatic drive(input int idx, input logic cyc, input logic stb,
                       input logic [2:0] cti, input logic [AW-1:0] adr);
    if (idx == 0) begin
      m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.cti = cti; m0_bus.adr = adr;
      m0_bus.we = 1'b0; m0_bus.wdat = adr ^ 32'h5a5a_5a5a; m0_bus.sel = 4'hf; m0_bus.bte = 2'b00;
    end else begin
      m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.cti = cti; m1_bus.adr = adr;
      m1_bus.we = 1'b1; m1_bus.wdat = adr ^ 32'hc3c3_c3c3; m1_bus.sel = 4'h3; m1_bus.bte = 2'b01;
    end
  endtask

  task automatic slave(input logic ack, input logic err, input logic rty, input logic [DW-1:0] dat);
    s_bus.ack = ack; s_bus.err = err; s_bus.rty = rty; s_bus.rdat = dat;
  endtask

  task automatic adv();
    @(posedge wb_clk);
    #1;
  endtask

  // Compare all outputs with the model at the falling edge, then advance the
  // model to the state it will hold after the next rising edge.
  task automatic sample();
    logic m_cyc, m_stb, m_we;
    logic [2:0] m_cti;
    logic [1:0] m_bte;
    logic [3:0] m_sel;
    logic [31:0] m_adr, m_dat;
    logic live, abort, done, any_rsp;
    logic [75:0] exp_req, obs_req;
    logic [2:0] rsp, exp_m0, exp_m1;
    logic [1:0] exp_gnt;
    int nxt;
    @(negedge wb_clk);
    {m_cyc, m_stb, m_we, m_cti, m_bte, m_sel, m_adr, m_dat} = '0;
    if (owner == 1)
      {m_cyc, m_stb, m_we, m_cti, m_bte, m_sel, m_adr, m_dat} =
        {m0_bus.cyc, m0_bus.stb, m0_bus.we, m0_bus.cti, m0_bus.bte, m0_bus.sel, m0_bus.adr, m0_bus.wdat};
    else if (owner == 2)
      {m_cyc, m_stb, m_we, m_cti, m_bte, m_sel, m_adr, m_dat} =
        {m1_bus.cyc, m1_bus.stb, m1_bus.we, m1_bus.cti, m1_bus.bte, m1_bus.sel, m1_bus.adr, m1_bus.wdat};
    live    = (owner != 0) && m_cyc && m_stb;
    abort   = live && (stall == TO - 1);
    exp_req = {m_cyc && !abort, live && !abort, m_we, m_cti, m_bte, m_sel, m_adr, m_dat};
    rsp     = (owner == 0) ? 3'b000 :
              {s_bus.ack && !abort, (s_bus.err && !abort) || abort, s_bus.rty && !abort};
    exp_m0  = (owner == 1) ? rsp : 3'b000;
    exp_m1  = (owner == 2) ? rsp : 3'b000;
    exp_gnt = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
    obs_req = {s_bus.cyc, s_bus.stb, s_bus.we, s_bus.cti, s_bus.bte, s_bus.sel, s_bus.adr, s_bus.wdat};

    check("gnt", 128'(gnt), 128'(exp_gnt));
    check("timeout", 128'(tflag_dut), 128'(tf));
    check("s_req", 128'(obs_req), 128'(exp_req));
    check("m0_rsp", 128'({m0_bus.ack, m0_bus.err, m0_bus.rty}), 128'(exp_m0));
    check("m1_rsp", 128'({m1_bus.ack, m1_bus.err, m1_bus.rty}), 128'(exp_m1));
    check("m0_dat", 128'(m0_bus.rdat), 128'(s_bus.rdat));
    check("m1_dat", 128'(m1_bus.rdat), 128'(s_bus.rdat));

    if (!wb_rst_n) begin
      model_reset();
      return;
    end
    nxt = owner;
    any_rsp = s_bus.ack || s_bus.err || s_bus.rty;
    if (owner != 0) begin
      done = !m_cyc || abort || s_bus.err || s_bus.rty ||
             (s_bus.ack && (m_cti == 3'b000 || m_cti == 3'b111));
      if (done) nxt = 0;
      if (abort) tf = 1'b1;
      stall = (live && !abort && !any_rsp) ? stall + 1 : 0;
    end else begin
      stall = 0;
      if (m1_bus.cyc && wait1 == SL) nxt = 2;
      else if (m0_bus.cyc)           nxt = 1;
      else if (m1_bus.cyc)           nxt = 2;
    end
    if (!m1_bus.cyc)                    wait1 = 0;
    else if (owner != 2 && nxt == 2)    wait1 = 0;
    else if (owner != 2 && wait1 < SL)  wait1 = wait1 + 1;
    owner = nxt;
  endtask

  initial begin
    logic [1:0] seq [8];
    logic c0, c1;
    int r;
    seq = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

    wb_rst_n = 1'b0;
    drive(0, 0, 0, 3'b000, '0);
    drive(1, 0, 0, 3'b000, '0);
    slave(0, 0, 0, '0);
    model_reset();
    sample(); adv();
    drive(0, 1, 1, 3'b000, 32'h10);
    sample();
    check("rst_gnt", 128'(gnt), 128'(2'b00));
    check("rst_scyc", 128'(s_bus.cyc), 128'(1'b0));
    check("rst_timeout", 128'(tflag_dut), 128'(1'b0));
    adv();
    drive(0, 0, 0, 3'b000, '0);
    wb_rst_n = 1'b1;

    // single m1 classic read
    drive(1, 1, 1, 3'b000, 32'h100);
    sample(); check("t1_idle_gnt", 128'(gnt), 128'(2'b00)); adv();
    sample(); check("t1_gnt", 128'(gnt), 128'(2'b10)); adv();
    sample(); adv();
    slave(1, 0, 0, 32'hDEAD_BEEF);
    sample();
    check("t1_ack", 128'(m1_bus.ack), 128'(1'b1));
    check("t1_dat", 128'(m1_bus.rdat), 128'(32'hDEAD_BEEF));
    check("t1_m0ack", 128'(m0_bus.ack), 128'(1'b0));
    adv();
    slave(0, 0, 0, '0);
    drive(1, 0, 0, 3'b000, '0);
    sample(); check("t1_release", 128'(gnt), 128'(2'b00)); adv();

    // simultaneous requests, m0 4-beat incrementing burst
    drive(0, 1, 1, 3'b010, 32'h200);
    drive(1, 1, 1, 3'b000, 32'h300);
    sample(); adv();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 1, (k < 3) ? 3'b010 : 3'b111, 32'h200 + 32'(4 * k));
      slave(1, 0, 0, $urandom);
      sample();
      check("t2_gnt0", 128'(gnt), 128'(2'b01));
      check("t2_m0ack", 128'(m0_bus.ack), 128'(1'b1));
      check("t2_m1ack", 128'(m1_bus.ack), 128'(1'b0));
      adv();
    end
    slave(0, 0, 0, '0);
    drive(0, 0, 0, 3'b000, '0);
    sample(); check("t2_idle", 128'(gnt), 128'(2'b00)); adv();
    slave(1, 0, 0, 32'h1234_5678);
    sample();
    check("t2_gnt1", 128'(gnt), 128'(2'b10));
    check("t2_m1ack_end", 128'(m1_bus.ack), 128'(1'b1));
    adv();
    slave(0, 0, 0, '0);
    drive(1, 0, 0, 3'b000, '0);
    sample(); adv();

    // starvation: m0 back-to-back classic reads, m1 held requesting
    drive(0, 1, 1, 3'b000, 32'h240);
    drive(1, 1, 1, 3'b000, 32'h340);
    slave(1, 0, 0, 32'hA5A5_0000);
    for (int i = 0; i < 8; i++) begin
      sample(); check("t3_gnt", 128'(gnt), 128'(seq[i])); adv();
    end
    drive(0, 0, 0, 3'b000, '0);
    drive(1, 0, 0, 3'b000, '0);
    slave(0, 0, 0, '0);
    sample(); adv();

    // watchdog abort on a silent slave
    drive(0, 1, 1, 3'b000, 32'h400);
    sample(); adv();
    for (int i = 0; i < TO - 1; i++) begin
      sample();
      check("t4_noerr", 128'(m0_bus.err), 128'(1'b0));
      check("t4_scyc_hi", 128'(s_bus.cyc), 128'(1'b1));
      adv();
    end
    slave(1, 0, 0, 32'hBAD0_BAD0);
    sample();
    check("t4_err", 128'(m0_bus.err), 128'(1'b1));
    check("t4_late_ack", 128'(m0_bus.ack), 128'(1'b0));
    check("t4_scyc_lo", 128'(s_bus.cyc), 128'(1'b0));
    adv();
    slave(0, 0, 0, '0);
    drive(0, 0, 0, 3'b000, '0);
    drive(1, 1, 1, 3'b000, 32'h500);
    sample();
    check("t4_tflag", 128'(tflag_dut), 128'(1'b1));
    check("t4_idle", 128'(gnt), 128'(2'b00));
    adv();
    slave(1, 0, 0, 32'h0000_5555);
    sample();
    check("t4_m1_gnt", 128'(gnt), 128'(2'b10));
    check("t4_m1_ack", 128'(m1_bus.ack), 128'(1'b1));
    adv();
    slave(0, 0, 0, '0);
    drive(1, 0, 0, 3'b000, '0);
    sample(); adv();

    // asynchronous reset in the middle of an m0 burst
    drive(0, 1, 1, 3'b010, 32'h600);
    sample(); adv();
    slave(1, 0, 0, 32'h6666_0000);
    sample(); adv();
    sample();
    #2 wb_rst_n = 1'b0;
    #1;
    check("r_gnt", 128'(gnt), 128'(2'b00));
    check("r_scyc", 128'(s_bus.cyc), 128'(1'b0));
    check("r_tflag", 128'(tflag_dut), 128'(1'b0));
    check("r_ack", 128'(m0_bus.ack), 128'(1'b0));
    model_reset();
    adv();
    drive(0, 0, 0, 3'b000, '0);
    slave(0, 0, 0, '0);
    sample(); adv();
    wb_rst_n = 1'b1;

    // m0 abandons a stalled cycle, then a fresh cycle gets the full watchdog window
    drive(0, 1, 1, 3'b000, 32'h700);
    sample(); adv();
    sample(); adv();
    sample(); adv();
    drive(0, 0, 0, 3'b000, '0);
    sample();
    check("t6_scyc", 128'(s_bus.cyc), 128'(1'b0));
    check("t6_err", 128'(m0_bus.err), 128'(1'b0));
    adv();
    sample(); check("t6_idle", 128'(gnt), 128'(2'b00)); adv();
    drive(0, 1, 1, 3'b000, 32'h704);
    sample(); adv();
    for (int i = 0; i < TO - 1; i++) begin
      sample(); adv();
    end
    sample(); check("t6_err_full", 128'(m0_bus.err), 128'(1'b1)); adv();
    drive(0, 0, 0, 3'b000, '0);
    sample(); adv();

    // randomized traffic with occasional silent-slave windows
    c0 = 1'b0;
    c1 = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) c0 = ~c0;
      if ($urandom_range(7) == 0) c1 = ~c1;
      drive(0, c0, c0 && ($urandom_range(3) != 0), 3'b000, $urandom);
      drive(1, c1, c1 && ($urandom_range(3) != 0), 3'b000, $urandom);
      r = int'($urandom_range(2));
      m0_bus.cti = (r == 0) ? 3'b000 : (r == 1) ? 3'b010 : 3'b111;
      r = int'($urandom_range(2));
      m1_bus.cti = (r == 0) ? 3'b000 : (r == 1) ? 3'b010 : 3'b111;
      m0_bus.we = $urandom_range(1) == 1;
      m1_bus.sel = 4'($urandom);
      m1_bus.bte = 2'($urandom);
      r = int'($urandom_range(19));
      if (((i / 100) % 4) == 3) slave(0, 0, 0, $urandom);
      else                      slave(r < 8, r == 8, r == 9, $urandom);
      sample(); adv();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
